// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Debounces a raw, asynchronous pushbutton. The raw input is brought into the
// clk domain through a two-flop synchronizer. A new synchronized level is
// accepted only after it has held for DEBOUNCE_CYCLES consecutive cycles. Any
// return to the current level before then restarts the count from zero.
// A clean edge on button_raw reaches button exactly 2 + DEBOUNCE_CYCLES rising
// edges after it is first sampled.
//
// Parameters:
//   DEBOUNCE_CYCLES - cycles a new synchronized level must hold (2..65535)
//
// Ports:
//   clk        in  - single clock, all flops on its rising edge
//   reset_n    in  - asynchronous active-low reset
//   button_raw in  - raw bouncing pushbutton, 1 = pressed
//   button     out - debounced level, synchronous to clk
//   pressed    out - one-cycle pulse in the first cycle button reads 1
//   released   out - one-cycle pulse in the first cycle button reads 0
//
// Configuration macro:
//   BUTTON_DEBOUNCER_RELEASE_PULSE_EN - when defined, released is generated;
//   when undefined, released is tied to 0 and no logic is built for it.
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_raw,
  output logic button,
  output logic pressed,
  output logic released
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The state is never stored on its own; it is decoded from the counter and
  // the synchronizer/output comparison.
  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_button;
  logic             r_pressed;
  logic [CNT_W-1:0] r_count;

  logic             w_differ;
  state_t           w_state;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_accept;

  // Two-flop synchronizer; only r_sync2 is used by the debounce logic.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= button_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differ = (r_sync2 != r_button);
  assign w_state  = ((r_count != '0) || w_differ) ? ST_COUNTING : ST_STABLE;

  // Next count and acceptance. A match between r_sync2 and r_button always
  // clears the counter, so a bounce gets no partial credit. On the accepting
  // cycle the counter clears instead of wrapping.
  // NOTE: every output of this block is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_count_nxt = '0;
    w_accept    = 1'b0;
    case (w_state)
      ST_COUNTING: begin
        if (w_differ) begin
          if (r_count == CNT_LAST) begin
            w_accept = 1'b1;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end
      default: begin
        w_count_nxt = '0;
      end
    endcase
  end

  // NOTE: the reset here is asynchronous and clears every flop of the block;
  // there are no memories, so nothing is left relying on power-up values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_button  <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_pressed <= w_accept & r_sync2;
      if (w_accept) begin
        r_button <= r_sync2;
      end
    end
  end

  assign button  = r_button;
  assign pressed = r_pressed;

`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
  logic r_released;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_released <= 1'b0;
    end else begin
      r_released <= w_accept & ~r_sync2;
    end
  end

  assign released = r_released;
`else
  assign released = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES = 4. Expected
// outputs come from a table of hand-derived vectors, from hand-written corner
// sequences, and from a reference model that accepts a new level once the last
// DEBOUNCE_CYCLES synchronized samples all differ from the current output.
// The expected released behaviour follows BUTTON_DEBOUNCER_RELEASE_PULSE_EN.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int D = 4;

`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic button_raw;
  logic button;
  logic pressed;
  logic released;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .button_raw(button_raw),
    .button    (button),
    .pressed   (pressed),
    .released  (released)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: two-stage sample delay, then a sliding window of the last
  // D synchronized samples. The output flips when the whole window disagrees
  // with it; the window is emptied on acceptance and on reset.
  // ---------------------------------------------------------------------------
  bit m_s1, m_s2, m_button, m_pressed, m_released;
  bit m_hist[$];

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_button = 0; m_pressed = 0; m_released = 0;
    m_hist.delete();
  endfunction

  function automatic void model_edge(input bit raw);
    bit all_differ;
    m_hist.push_back(m_s2);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    m_pressed  = 0;
    m_released = 0;
    if (m_hist.size() == D) begin
      all_differ = 1;
      foreach (m_hist[i]) if (m_hist[i] == m_button) all_differ = 0;
      if (all_differ) begin
        m_button   = !m_button;
        m_pressed  = m_button;
        m_released = REL && !m_button;
        m_hist.delete();
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endfunction

  // One clock: drive input, let the edge happen, advance model, compare.
  task automatic tick(input bit raw);
    button_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    check("button",    button,             m_button);
    check("pressed",   pressed,            m_pressed);
    check("released",  released,           m_released);
    check("exclusive", pressed & released, 1'b0);
  endtask

  // Asserted between edges; outputs must clear without any clock.
  task automatic apply_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_button",   button,   1'b0);
    check("rst_async_pressed",  pressed,  1'b0);
    check("rst_async_released", released, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_button", button, 1'b0);
    reset_n = 1'b1;
  endtask

  // Holds a level and reports the edge on which button reaches it.
  task automatic measure_change(input bit lvl, input string tag);
    int change_edge = -1;
    int n_press     = 0;
    int n_rel       = 0;
    for (int e = 1; e <= 12; e++) begin
      tick(lvl);
      if (pressed)  n_press++;
      if (released) n_rel++;
      if (button == lvl && change_edge < 0) change_edge = e;
    end
    check({tag, "_edge"},     change_edge, 32'(D + 2));
    check({tag, "_pressed"},  n_press,     lvl ? 32'd1 : 32'd0);
    check({tag, "_released"}, n_rel,       (!lvl && REL) ? 32'd1 : 32'd0);
  endtask

  typedef struct {
    bit raw;
    bit exp_button;
    bit exp_pressed;
    bit exp_released;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int n_high;
    bit lvl;

    // Clean press then clean release, one row per clock edge.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{raw: 1'b1, exp_button: (i >= 5), exp_pressed: (i == 5), exp_released: 1'b0};
    end
    for (int i = 8; i < 16; i++) begin
      vecs[i] = '{raw: 1'b0, exp_button: (i < 13), exp_pressed: 1'b0,
                  exp_released: REL && (i == 13)};
    end

    reset_n    = 1'b0;
    button_raw = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_button",   button,   1'b0);
    check("reset_pressed",  pressed,  1'b0);
    check("reset_released", released, 1'b0);
    reset_n = 1'b1;

    // Table-driven clean press / release.
    for (int i = 0; i < 16; i++) begin
      tick(vecs[i].raw);
      check($sformatf("vec%0d_button", i),   button,   vecs[i].exp_button);
      check($sformatf("vec%0d_pressed", i),  pressed,  vecs[i].exp_pressed);
      check($sformatf("vec%0d_released", i), released, vecs[i].exp_released);
    end

    // Reset asserted while pressed is high, with button_raw still held.
    for (int i = 0; i < 10 && !pressed; i++) tick(1'b1);
    check("pulse_before_reset", pressed, 1'b1);
    apply_reset();
    measure_change(1'b1, "after_reset");
    measure_change(1'b0, "release");

    // Bounce 1,0,1,0 then steady 1.
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
    check("bounce_no_change", button, 1'b0);
    measure_change(1'b1, "bounce");
    measure_change(1'b0, "bounce_release");

    // Glitch shorter than D cycles.
    n_high = 0;
    for (int i = 0; i < 13; i++) begin
      tick(i < 3);
      n_high += int'(button) + int'(pressed) + int'(released);
    end
    check("glitch_outputs_high", n_high, 0);

    // Reset two cycles into a press.
    n_high = 0;
    tick(1'b1); n_high += int'(pressed);
    tick(1'b1); n_high += int'(pressed);
    check("midcount_no_early_press", n_high, 0);
    apply_reset();
    measure_change(1'b1, "midcount");
    measure_change(1'b0, "midcount_release");

    // Random runs of random length against the model.
    lvl = 1'b0;
    for (int r = 0; r < 400; r++) begin
      int len;
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) tick(lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
